// File: rtl/fft_rr_scheduler.sv
// Round-robin scheduler that shares one FFT core among N_CH capture FIFOs.
// Arbitrates per frame, frames the send/receive phases and aborts a stalled core.
module fft_rr_scheduler #(
    parameter int N_CH       = 4,
    parameter int FFT_POINTS = 1024,
    parameter int LVL_W      = 12,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 8192
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic [N_CH-1:0]         i_ch_mask,
    input  logic [N_CH*LVL_W-1:0]   i_ch_level,
    input  logic                    i_send_done,
    input  logic                    i_recv_done,
    output logic [N_CH-1:0]         o_grant,
    output logic [2:0]              o_grant_id,
    output logic                    o_fft_start,
    output logic                    o_fft_abort,
    output logic                    o_busy,
    output logic                    o_timeout_err,
    output logic [15:0]             o_frame_cnt
);

    localparam int WD_W  = $clog2(TIMEOUT) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_START = 3'd2,
        S_SEND  = 3'd3,
        S_RECV  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t             r_state;
    logic [N_CH-1:0]    r_grant;
    logic [2:0]         r_grant_id;
    logic               r_fft_start;
    logic               r_fft_abort;
    logic               r_busy;
    logic               r_timeout_err;
    logic [15:0]        r_frame_cnt;
    logic [WD_W-1:0]    r_wd;
    logic [GAP_W-1:0]   r_gap;

    logic [N_CH-1:0]    w_req;
    logic [N_CH-1:0]    w_rot;
    logic               w_found;
    logic [2:0]         w_win;
    int                 w_idx;

    always_comb begin
        w_req = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_req[i] = i_ch_mask[i] &&
                       (i_ch_level[i*LVL_W +: LVL_W] >= LVL_W'(FFT_POINTS));
        end
    end

    // Search begins one past the last owner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_grant_id;
        w_idx   = 0;
        w_rot   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            w_idx = (int'(r_grant_id) + k) % N_CH;
            w_rot = w_req >> w_idx;
            if (!w_found && w_rot[0]) begin
                w_found = 1'b1;
                w_win   = 3'(w_idx);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_id    <= 3'(N_CH - 1);
            r_fft_start   <= 1'b0;
            r_fft_abort   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_frame_cnt   <= 16'd0;
            r_wd          <= '0;
            r_gap         <= '0;
        end else begin
            r_fft_start <= 1'b0;
            r_fft_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_enable && (|w_req)) begin
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (w_found) begin
                        r_grant     <= N_CH'(1) << w_win;
                        r_grant_id  <= w_win;
                        r_fft_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_START;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    r_wd    <= '0;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (i_send_done) begin
                        r_wd    <= '0;
                        r_state <= S_RECV;
                    end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        r_fft_abort   <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_grant       <= '0;
                        r_busy        <= 1'b0;
                        r_gap         <= '0;
                        r_state       <= S_GAP;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                // A completion arriving on the last watchdog cycle still counts.
                S_RECV: begin
                    if (i_recv_done) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_grant     <= '0;
                        r_busy      <= 1'b0;
                        r_gap       <= '0;
                        r_state     <= S_GAP;
                    end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        r_fft_abort   <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_grant       <= '0;
                        r_busy        <= 1'b0;
                        r_gap         <= '0;
                        r_state       <= S_GAP;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
                        r_gap   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_id    = r_grant_id;
    assign o_fft_start   = r_fft_start;
    assign o_fft_abort   = r_fft_abort;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_timeout_err;
    assign o_frame_cnt   = r_frame_cnt;

endmodule
